// File: rtl/comparator_stream_stats_pkg.sv
// comparator_stream_stats_pkg: shared state encoding and sample width.
package comparator_stream_stats_pkg;
  localparam int SW = 2;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FIRST = 2'b01,
    RUN   = 2'b10,
    DONE  = 2'b11
  } state_t;
endpackage

// File: rtl/comparator_stream_stats_if.sv
// comparator_stream_stats_if: sample stream in, run statistics out.
interface comparator_stream_stats_if
  import comparator_stream_stats_pkg::*;
#(
  parameter int CW = 4
);
  logic          start;
  logic          in_valid;
  logic [SW-1:0] in_data;
  logic          in_ready;
  logic [SW-1:0] max_out;
  logic [SW-1:0] min_out;
  logic [CW-1:0] gt_cnt;
  logic [CW-1:0] eq_cnt;
  logic [CW-1:0] lt_cnt;
  logic          busy;
  logic          done;
  modport master (
    output start, in_valid, in_data,
    input  in_ready, max_out, min_out, gt_cnt, eq_cnt, lt_cnt, busy, done
  );
  modport slave (
    input  start, in_valid, in_data,
    output in_ready, max_out, min_out, gt_cnt, eq_cnt, lt_cnt, busy, done
  );
endinterface

// File: rtl/comparator_stream_stats_cmp2_flags.sv
// cmp2_flags: unsigned 2-bit magnitude compare with one-hot gt/eq/lt.
module cmp2_flags
  import comparator_stream_stats_pkg::*;
(
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  output logic          gt,
  output logic          eq,
  output logic          lt
);
  assign gt = a > b;
  assign eq = a == b;
  assign lt = a < b;
endmodule

// File: rtl/comparator_stream_stats.sv
// comparator_stream_stats: collects max/min and successor-trend counts over N_SAMPLES samples.
module comparator_stream_stats
  import comparator_stream_stats_pkg::*;
#(
  parameter int N_SAMPLES = 8,
  parameter int CW        = 4
)(
  input  logic clk,
  input  logic rst_n,
  comparator_stream_stats_if.slave bus
);
  state_t        state;
  logic [SW-1:0] prev;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          p_gt, p_eq, p_lt;
  logic          m_gt, m_eq, m_lt;
  logic          n_gt, n_eq, n_lt;
  logic [SW-1:0] max_next;
  logic [SW-1:0] min_next;

  cmp2_flags u_prev (.a(bus.in_data), .b(prev),        .gt(p_gt), .eq(p_eq), .lt(p_lt));
  cmp2_flags u_max  (.a(bus.in_data), .b(bus.max_out), .gt(m_gt), .eq(m_eq), .lt(m_lt));
  cmp2_flags u_min  (.a(bus.in_data), .b(bus.min_out), .gt(n_gt), .eq(n_eq), .lt(n_lt));

  assign accept = bus.in_valid && bus.in_ready;
  // One-hot flags select between the new sample and the held extreme
  assign max_next = ({SW{m_gt}} & bus.in_data) | ({SW{m_eq | m_lt}} & bus.max_out);
  assign min_next = ({SW{n_lt}} & bus.in_data) | ({SW{n_eq | n_gt}} & bus.min_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      prev         <= '0;
      cnt          <= '0;
      bus.max_out  <= '0;
      bus.min_out  <= '0;
      bus.gt_cnt   <= '0;
      bus.eq_cnt   <= '0;
      bus.lt_cnt   <= '0;
      bus.in_ready <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state        <= FIRST;
          cnt          <= '0;
          bus.gt_cnt   <= '0;
          bus.eq_cnt   <= '0;
          bus.lt_cnt   <= '0;
          bus.in_ready <= 1'b1;
          bus.busy     <= 1'b1;
        end
        FIRST: if (accept) begin
          prev        <= bus.in_data;
          bus.max_out <= bus.in_data;
          bus.min_out <= bus.in_data;
          cnt         <= CW'(1);
          if (N_SAMPLES == 1) begin
            state        <= DONE;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        RUN: if (accept) begin
          prev        <= bus.in_data;
          bus.max_out <= max_next;
          bus.min_out <= min_next;
          bus.gt_cnt  <= bus.gt_cnt + CW'(p_gt);
          bus.eq_cnt  <= bus.eq_cnt + CW'(p_eq);
          bus.lt_cnt  <= bus.lt_cnt + CW'(p_lt);
          cnt         <= cnt + CW'(1);
          if (cnt == CW'(N_SAMPLES - 1)) begin
            state        <= DONE;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          bus.done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_comparator_stream_stats.sv
// tb_comparator_stream_stats: directed scenarios on a 4-sample and a 1-sample instance.
module tb_comparator_stream_stats;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  comparator_stream_stats_if #(.CW(4)) bus4 ();
  comparator_stream_stats_if #(.CW(4)) bus1 ();

  comparator_stream_stats #(.N_SAMPLES(4), .CW(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  comparator_stream_stats #(.N_SAMPLES(1), .CW(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  // {max, min, gt, eq, lt} and {done, busy, in_ready} snapshots
  function automatic logic [15:0] res4();
    return {bus4.max_out, bus4.min_out, bus4.gt_cnt, bus4.eq_cnt, bus4.lt_cnt};
  endfunction
  function automatic logic [2:0] st4();
    return {bus4.done, bus4.busy, bus4.in_ready};
  endfunction
  function automatic logic [15:0] res1();
    return {bus1.max_out, bus1.min_out, bus1.gt_cnt, bus1.eq_cnt, bus1.lt_cnt};
  endfunction
  function automatic logic [2:0] st1();
    return {bus1.done, bus1.busy, bus1.in_ready};
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus4.in_valid && bus4.in_ready) begin
      total++;
      if (!$onehot({dut4.u_prev.gt, dut4.u_prev.eq, dut4.u_prev.lt}) ||
          !$onehot({dut4.u_max.gt, dut4.u_max.eq, dut4.u_max.lt}) ||
          !$onehot({dut4.u_min.gt, dut4.u_min.eq, dut4.u_min.lt})) begin
        bad++;
        $display("FAIL flags_onehot: prev=%b max=%b min=%b required one-hot",
                 {dut4.u_prev.gt, dut4.u_prev.eq, dut4.u_prev.lt},
                 {dut4.u_max.gt, dut4.u_max.eq, dut4.u_max.lt},
                 {dut4.u_min.gt, dut4.u_min.eq, dut4.u_min.lt});
      end
    end
    if (rst_n && bus4.done) begin
      total++;
      if (int'(bus4.gt_cnt) + int'(bus4.eq_cnt) + int'(bus4.lt_cnt) != 3) begin
        bad++;
        $display("FAIL done_invariant: sum=%0d required 3",
                 int'(bus4.gt_cnt) + int'(bus4.eq_cnt) + int'(bus4.lt_cnt));
      end
    end
  end

  task automatic start4();
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
  endtask

  task automatic drive4(input logic [1:0] v0, input logic [1:0] v1,
                        input logic [1:0] v2, input logic [1:0] v3);
    logic [1:0] v[4];
    v = '{v0, v1, v2, v3};
    for (int i = 0; i < 4; i++) begin
      bus4.in_valid = 1'b1;
      bus4.in_data  = v[i];
      @(negedge clk);
    end
    bus4.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if (res4() !== 16'h0 || st4() !== 3'b000) begin
      bad++;
      $display("FAIL reset_state: res=%h st=%b required 0000 000", res4(), st4());
    end
    rst_n = 1'b1;
    bus4.in_valid = 1'b1;
    bus4.in_data  = 2'd3;
    repeat (2) @(negedge clk);
    bus4.in_valid = 1'b0;
    total++;
    if (res4() !== 16'h0 || st4() !== 3'b000) begin
      bad++;
      $display("FAIL idle_ignores_valid: res=%h st=%b required 0000 000", res4(), st4());
    end
    start4();
    total++;
    if (st4() !== 3'b011) begin
      bad++;
      $display("FAIL start_enters_first: st=%b required 011", st4());
    end
  endtask

  task automatic test_back_to_back();
    drive4(2'd1, 2'd3, 2'd3, 2'd0);
    total++;
    if (st4() !== 3'b100) begin
      bad++;
      $display("FAIL b2b_done_latency: st=%b required 100", st4());
    end
    total++;
    if (res4() !== {2'd3, 2'd0, 4'd1, 4'd1, 4'd1}) begin
      bad++;
      $display("FAIL b2b_results: res=%h required %h", res4(), {2'd3, 2'd0, 4'd1, 4'd1, 4'd1});
    end
    @(negedge clk);
    total++;
    if (st4() !== 3'b000) begin
      bad++;
      $display("FAIL b2b_done_one_cycle: st=%b required 000", st4());
    end
    repeat (3) @(negedge clk);
    total++;
    if (res4() !== {2'd3, 2'd0, 4'd1, 4'd1, 4'd1}) begin
      bad++;
      $display("FAIL b2b_results_hold: res=%h required %h", res4(), {2'd3, 2'd0, 4'd1, 4'd1, 4'd1});
    end
  endtask

  task automatic test_gaps();
    start4();
    total++;
    if ({bus4.gt_cnt, bus4.eq_cnt, bus4.lt_cnt} !== 12'h0) begin
      bad++;
      $display("FAIL start_clears_counters: cnts=%h required 000",
               {bus4.gt_cnt, bus4.eq_cnt, bus4.lt_cnt});
    end
    for (int i = 0; i < 4; i++) begin
      bus4.in_valid = 1'b1;
      bus4.in_data  = 2'd2;
      @(negedge clk);
      bus4.in_valid = 1'b0;
      bus4.in_data  = 2'd3;
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          total++;
          if (bus4.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL gap_ready: sample=%0d gap=%0d in_ready=%b required 1", i, g, bus4.in_ready);
          end
          @(negedge clk);
        end
      end
    end
    total++;
    if (st4() !== 3'b100 || res4() !== {2'd2, 2'd2, 4'd0, 4'd3, 4'd0}) begin
      bad++;
      $display("FAIL gaps_results: st=%b res=%h required 100 %h", st4(), res4(),
               {2'd2, 2'd2, 4'd0, 4'd3, 4'd0});
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    start4();
    bus4.in_valid = 1'b1;
    bus4.in_data  = 2'd3;
    @(negedge clk);
    bus4.in_data  = 2'd1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (st4() !== 3'b000 || res4() !== 16'h0) begin
      bad++;
      $display("FAIL async_reset: st=%b res=%h required 000 0000", st4(), res4());
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (st4() !== 3'b000) begin
      bad++;
      $display("FAIL abort_no_done: st=%b required 000", st4());
    end
    start4();
    drive4(2'd0, 2'd1, 2'd2, 2'd3);
    total++;
    if (st4() !== 3'b100 || res4() !== {2'd3, 2'd0, 4'd3, 4'd0, 4'd0}) begin
      bad++;
      $display("FAIL rerun_results: st=%b res=%h required 100 %h", st4(), res4(),
               {2'd3, 2'd0, 4'd3, 4'd0, 4'd0});
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    start4();
    bus4.in_valid = 1'b1;
    bus4.in_data  = 2'd3;
    @(negedge clk);
    bus4.in_data  = 2'd2;
    bus4.start    = 1'b1;
    @(negedge clk);
    bus4.start    = 1'b0;
    bus4.in_data  = 2'd1;
    @(negedge clk);
    bus4.in_data  = 2'd0;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    total++;
    if (st4() !== 3'b100) begin
      bad++;
      $display("FAIL start_in_run: st=%b required 100", st4());
    end
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    total++;
    if (st4() !== 3'b000 || res4() !== {2'd3, 2'd0, 4'd0, 4'd0, 4'd3}) begin
      bad++;
      $display("FAIL start_in_done: st=%b res=%h required 000 %h", st4(), res4(),
               {2'd3, 2'd0, 4'd0, 4'd0, 4'd3});
    end
    @(negedge clk);
    total++;
    if (st4() !== 3'b000) begin
      bad++;
      $display("FAIL no_restart_after_done: st=%b required 000", st4());
    end
  endtask

  task automatic test_single();
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    total++;
    if (st1() !== 3'b011) begin
      bad++;
      $display("FAIL single_start: st=%b required 011", st1());
    end
    bus1.in_valid = 1'b1;
    bus1.in_data  = 2'd2;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    total++;
    if (st1() !== 3'b100 || res1() !== {2'd2, 2'd2, 4'd0, 4'd0, 4'd0}) begin
      bad++;
      $display("FAIL single_results: st=%b res=%h required 100 %h", st1(), res1(),
               {2'd2, 2'd2, 4'd0, 4'd0, 4'd0});
    end
    @(negedge clk);
    total++;
    if (st1() !== 3'b000) begin
      bad++;
      $display("FAIL single_done_pulse: st=%b required 000", st1());
    end
  endtask

  initial begin
    bus4.start = 1'b0;
    bus4.in_valid = 1'b0;
    bus4.in_data = 2'd0;
    bus1.start = 1'b0;
    bus1.in_valid = 1'b0;
    bus1.in_data = 2'd0;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_abort();
    test_start_ignored();
    test_single();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/comparator_stream_stats.md
COMPARATOR_STREAM_STATS -- requirements
Module: comparator_stream_stats

Interface
REQ-001 Parameter N_SAMPLES, default 8, number of 2-bit samples per measurement run (legal range 1..15).
REQ-002 Parameter CW, default 4, width of event counters; SHALL hold N_SAMPLES (CW >= clog2(N_SAMPLES+1)).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin a run; honoured only in IDLE.
REQ-006 in_valid  input  1  upstream sample valid.
REQ-007 in_data  input  2  sample value; bit 1 = MSB (A), bit 0 = LSB (B).
REQ-008 in_ready  output  1  block can accept a sample this cycle.
REQ-009 max_out  output  2  largest sample of the run.
REQ-010 min_out  output  2  smallest sample of the run.
REQ-011 gt_cnt  output  CW  count of samples strictly greater than their predecessor.
REQ-012 eq_cnt  output  CW  count of samples equal to their predecessor.
REQ-013 lt_cnt  output  CW  count of samples strictly less than their predecessor.
REQ-014 busy  output  1  high in FIRST and RUN.
REQ-015 done  output  1  one-cycle pulse when a run completes.

Function
REQ-016 Sample accepted only on a clock edge where in_valid && in_ready; no other edge changes sample state.
REQ-017 FSM states: IDLE, FIRST, RUN, DONE; encoded per shared package.
REQ-018 IDLE: in_ready=0, busy=0; start=1 -> FIRST and clears gt_cnt, eq_cnt, lt_cnt, sample count.
REQ-019 FIRST: in_ready=1; on accept: max_out=min_out=prev=in_data, sample count=1; -> DONE if N_SAMPLES==1, else -> RUN.
REQ-020 RUN: in_ready=1; on accept compare in_data vs prev: exactly one of gt_cnt/eq_cnt/lt_cnt increments by 1.
REQ-021 RUN accept: max_out updates if in_data > max_out; min_out updates if in_data < min_out; prev=in_data; sample count +1.
REQ-022 RUN: accept making sample count == N_SAMPLES -> DONE on that edge.
REQ-023 DONE: done=1, in_ready=0, busy=0 for exactly one cycle; unconditionally -> IDLE.
REQ-024 Latency: done asserted the cycle immediately following the N_SAMPLES-th accept.
REQ-025 Results (max_out, min_out, counters) hold from DONE until the next accepted start.
REQ-026 start outside IDLE ignored (no restart, no counter change), including start in DONE.
REQ-027 in_valid while in_ready=0 has no effect; upstream holds data (no drop required of this block).
REQ-028 Invariant at DONE: gt_cnt + eq_cnt + lt_cnt == N_SAMPLES - 1.
REQ-029 Comparisons unsigned 2-bit; counters never wrap for legal N_SAMPLES.

Reset
REQ-030 rst_n low asynchronously forces IDLE; max_out=0, min_out=0, counters=0, prev=0, sample count=0, done=0, busy=0, in_ready=0.
REQ-031 Reset mid-run discards the partial run; no done pulse produced.
REQ-032 After rst_n deasserts, first action possible is start on the next rising edge.

Structure
REQ-033 Shared package holds state encoding (IDLE=2'b00, FIRST=2'b01, RUN=2'b10, DONE=2'b11) and sample width constant (2).
REQ-034 One sub-module cmp2_flags: combinational compare of two 2-bit operands producing gt, eq, lt (exactly one high); three instances (vs prev, vs max, vs min).
REQ-035 No other sub-modules; counters and FSM in the top module.

Verification (N_SAMPLES=4 unless noted)
REQ-036 start, samples 1,3,3,0 back-to-back -> max_out=3, min_out=0, gt=1, eq=1, lt=1, done one cycle after 4th accept.
REQ-037 Samples 2,2,2,2 with in_valid gaps of 3 cycles -> max=min=2, gt=0, eq=3, lt=0; in_ready stays 1 through gaps.
REQ-038 rst_n low after 2 accepts, then new run 0,1,2,3 -> no done during aborted run; final max=3, min=0, gt=3, eq=0, lt=0.
REQ-039 start pulsed during RUN and during DONE -> no effect; results of run 3,2,1,0 read max=3, min=0, lt=3.
REQ-040 N_SAMPLES=1, start, sample 2 -> done next cycle, max=min=2, all counters 0.
REQ-041 Every accepted cycle: check cmp2_flags one-hot and REQ-028 invariant at each done.
